// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus device-side responder.
package hyperbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LATENCY,
    ST_READ,
    ST_WRITE,
    ST_REG_WR,
    ST_DONE
  } state_e;

  // Bit positions within CA word 0 (CA[47:32])
  localparam int unsigned CA0_RW_BIT = 15;
  localparam int unsigned CA0_AS_BIT = 14;
  localparam int unsigned CA0_BT_BIT = 13;

  localparam logic [31:0] REG_ID0 = 32'h0000_0000;
  localparam logic [31:0] REG_ID1 = 32'h0000_0001;
  localparam logic [31:0] REG_CR0 = 32'h0000_0800;
  localparam logic [31:0] REG_CR1 = 32'h0000_0801;

  localparam logic [15:0] CR0_RESET = 16'h8F1F;
  localparam logic [15:0] CR1_RESET = 16'h0002;

endpackage

// File: rtl/hyperbus_mem_responder_if.sv
// Word-per-cycle HyperBus pins as seen by the responder (slave) and the PHY (master).
interface hyperbus_mem_responder_if;
  logic        hyper_cs_ni;
  logic        ck_en_i;
  logic [15:0] dq_word_i;
  logic [1:0]  rwds_pair_i;
  logic [15:0] dq_word_o;
  logic        dq_oe_o;
  logic [1:0]  rwds_pair_o;
  logic        rwds_oe_o;

  modport master (
    output hyper_cs_ni, ck_en_i, dq_word_i, rwds_pair_i,
    input  dq_word_o, dq_oe_o, rwds_pair_o, rwds_oe_o
  );

  modport slave (
    input  hyper_cs_ni, ck_en_i, dq_word_i, rwds_pair_i,
    output dq_word_o, dq_oe_o, rwds_pair_o, rwds_oe_o
  );
endinterface

// File: rtl/hyperbus_resp_regs.sv
// Device register file: read-only ID0/ID1, writable CR0/CR1, combinational read.
module hyperbus_resp_regs
  import hyperbus_pkg::*;
#(
  parameter logic [15:0] ID0_VALUE = 16'h0C81,
  parameter logic [15:0] ID1_VALUE = 16'h0001
) (
  input  logic        clk270,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [15:0] wdata_i,
  input  logic [31:0] raddr_i,
  output logic [15:0] rdata_o,
  output logic        cr0_lat2x_o
);

  logic [15:0] cr0_q, cr1_q;

  always_ff @(posedge clk270 or negedge rst_ni) begin
    if (!rst_ni) begin
      cr0_q <= CR0_RESET;
      cr1_q <= CR1_RESET;
    end else if (we_i) begin
      if (waddr_i == REG_CR0) cr0_q <= wdata_i;
      if (waddr_i == REG_CR1) cr1_q <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      REG_ID0: rdata_o = ID0_VALUE;
      REG_ID1: rdata_o = ID1_VALUE;
      REG_CR0: rdata_o = cr0_q;
      REG_CR1: rdata_o = cr1_q;
      default: rdata_o = '0;
    endcase
  end

  assign cr0_lat2x_o = cr0_q[3];

endmodule

// File: rtl/hyperbus_mem_responder.sv
// HyperBus device responder: CA decode, initial latency, linear/wrapped bursts to a backend port.
module hyperbus_mem_responder
  import hyperbus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 6,
  parameter logic [15:0] ID0_VALUE   = 16'h0C81,
  parameter logic [15:0] ID1_VALUE   = 16'h0001,
  parameter int unsigned WRAP_WORDS  = 16
) (
  input  logic                      clk270,
  input  logic                      rst_ni,
  hyperbus_mem_responder_if.slave   bus,
  input  logic                      lat2x_req_i,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [31:0]               mem_addr_o,
  output logic [15:0]               mem_wdata_o,
  output logic [1:0]                mem_be_o,
  input  logic [15:0]               mem_rdata_i,
  output logic                      busy_o
);

  localparam logic [7:0]  LAT_1X    = 8'(WAIT_CYCLES);
  localparam logic [7:0]  LAT_2X    = 8'(2 * WAIT_CYCLES);
  localparam logic [31:0] WRAP_MASK = 32'(WRAP_WORDS - 1);

  state_e      state_q;
  logic [15:0] ca0_q, ca1_q;
  logic        ca_idx_q, dbl_q, is_read_q, is_reg_q, linear_q;
  logic [31:0] addr_q, addr_next;
  logic [7:0]  lat_q;
  logic        rd_pend_q, dq_oe_q, rwds_oe_q;
  logic [1:0]  rwds_q;
  logic [15:0] hold_q, dq_word, reg_rdata;
  logic        cr0_lat2x, live, lat_last, rd_issue, wr_issue, reg_we, dbl_now;

  assign live     = !bus.hyper_cs_ni && bus.ck_en_i;
  assign lat_last = (state_q == ST_LATENCY) && (lat_q == 8'd1);
  assign rd_issue = live && is_read_q && !is_reg_q && (lat_last || state_q == ST_READ);
  assign wr_issue = live && (state_q == ST_WRITE) && (bus.rwds_pair_i != 2'b11);
  assign reg_we   = live && (state_q == ST_REG_WR);
  assign dbl_now  = cr0_lat2x | lat2x_req_i;

  assign addr_next = linear_q ? addr_q + 32'd1
                              : (addr_q & ~WRAP_MASK) | ((addr_q + 32'd1) & WRAP_MASK);

  assign mem_req_o   = rd_issue | wr_issue;
  assign mem_we_o    = wr_issue;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wr_issue ? bus.dq_word_i : '0;
  assign mem_be_o    = wr_issue ? ~bus.rwds_pair_i : '0;
  assign busy_o      = (state_q != ST_IDLE);

  // Backend data shows up only in the cycle after its request; hold_q keeps it across stalls.
  assign dq_word         = !dq_oe_q ? '0 : (rd_pend_q ? mem_rdata_i : hold_q);
  assign bus.dq_word_o   = dq_word;
  assign bus.dq_oe_o     = dq_oe_q;
  assign bus.rwds_oe_o   = rwds_oe_q;
  assign bus.rwds_pair_o = rwds_q;

  hyperbus_resp_regs #(
    .ID0_VALUE (ID0_VALUE),
    .ID1_VALUE (ID1_VALUE)
  ) u_regs (
    .clk270      (clk270),
    .rst_ni      (rst_ni),
    .we_i        (reg_we),
    .waddr_i     (addr_q),
    .wdata_i     (bus.dq_word_i),
    .raddr_i     (addr_q),
    .rdata_o     (reg_rdata),
    .cr0_lat2x_o (cr0_lat2x)
  );

  always_ff @(posedge clk270 or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      ca0_q     <= '0;
      ca1_q     <= '0;
      ca_idx_q  <= 1'b0;
      dbl_q     <= 1'b0;
      is_read_q <= 1'b0;
      is_reg_q  <= 1'b0;
      linear_q  <= 1'b0;
      addr_q    <= '0;
      lat_q     <= '0;
      rd_pend_q <= 1'b0;
      hold_q    <= '0;
      dq_oe_q   <= 1'b0;
      rwds_oe_q <= 1'b0;
      rwds_q    <= '0;
    end else if (bus.hyper_cs_ni) begin
      state_q   <= ST_IDLE;
      rd_pend_q <= 1'b0;
      dq_oe_q   <= 1'b0;
      rwds_oe_q <= 1'b0;
      rwds_q    <= '0;
    end else begin
      rd_pend_q <= rd_issue;
      if (live && is_reg_q && (lat_last || state_q == ST_READ)) hold_q <= reg_rdata;
      else                                                       hold_q <= dq_word;

      if (bus.ck_en_i) begin
        case (state_q)
          ST_IDLE: begin
            ca0_q     <= bus.dq_word_i;
            dbl_q     <= dbl_now;
            ca_idx_q  <= 1'b0;
            rwds_oe_q <= 1'b1;
            rwds_q    <= {2{dbl_now}};
            state_q   <= ST_CA;
          end
          ST_CA: begin
            if (!ca_idx_q) begin
              ca1_q    <= bus.dq_word_i;
              ca_idx_q <= 1'b1;
            end else begin
              is_read_q <= ca0_q[CA0_RW_BIT];
              is_reg_q  <= ca0_q[CA0_AS_BIT];
              linear_q  <= ca0_q[CA0_BT_BIT];
              addr_q    <= {ca0_q[12:0], ca1_q, bus.dq_word_i[2:0]};
              rwds_oe_q <= 1'b0;
              rwds_q    <= '0;
              lat_q     <= dbl_q ? LAT_2X : LAT_1X;
              if (!ca0_q[CA0_RW_BIT] && ca0_q[CA0_AS_BIT]) state_q <= ST_REG_WR;
              else                                         state_q <= ST_LATENCY;
            end
          end
          ST_LATENCY: begin
            lat_q <= lat_q - 8'd1;
            if (lat_q == 8'd1) begin
              if (is_read_q) begin
                addr_q    <= addr_next;
                dq_oe_q   <= 1'b1;
                rwds_oe_q <= 1'b1;
                rwds_q    <= 2'b10;
                state_q   <= ST_READ;
              end else begin
                state_q   <= ST_WRITE;
              end
            end
          end
          ST_READ:   addr_q  <= addr_next;
          ST_WRITE:  addr_q  <= addr_next;
          ST_REG_WR: state_q <= ST_DONE;
          ST_DONE:   state_q <= ST_DONE;
          default:   state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hyperbus_mem_responder.sv
// Scoreboard bench for hyperbus_mem_responder: stimulus queues expectations, monitors pop and compare.
module tb_hyperbus_mem_responder;
  localparam int WAIT = 6;

  logic        clk270 = 1'b0;
  logic        rst_ni;
  logic        lat2x_req_i;
  logic        mem_req_o, mem_we_o, busy_o;
  logic [31:0] mem_addr_o;
  logic [15:0] mem_wdata_o, mem_rdata_i;
  logic [1:0]  mem_be_o;

  hyperbus_mem_responder_if bus ();

  hyperbus_mem_responder #(
    .WAIT_CYCLES (WAIT),
    .ID0_VALUE   (16'h0C81),
    .ID1_VALUE   (16'h0001),
    .WRAP_WORDS  (16)
  ) dut (
    .clk270      (clk270),
    .rst_ni      (rst_ni),
    .bus         (bus),
    .lat2x_req_i (lat2x_req_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o)
  );

  always #5 clk270 = ~clk270;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_data_q [$];
  logic [31:0] exp_rd_q   [$];
  logic [49:0] exp_wr_q   [$];

  function automatic logic [15:0] memf(input logic [31:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [47:0] mk_ca(input logic rw, input logic as, input logic lin,
                                        input logic [31:0] a);
    return {rw, as, lin, a[31:3], 13'd0, a[2:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // Backend: data valid only in the cycle after a read request, junk otherwise.
  always @(posedge clk270)
    mem_rdata_i <= (mem_req_o && !mem_we_o) ? memf(mem_addr_o) : 16'hDEAD;

  always @(negedge clk270) begin
    if (rst_ni === 1'b1) begin
      if (bus.dq_oe_o && bus.ck_en_i && !bus.hyper_cs_ni) begin
        if (exp_data_q.size() == 0) unexpected("read_word", 64'(bus.dq_word_o));
        else check("read_data", 64'(bus.dq_word_o), 64'(exp_data_q.pop_front()));
      end
      if (mem_req_o) begin
        if (mem_we_o) begin
          if (exp_wr_q.size() == 0) unexpected("mem_write", {mem_addr_o, mem_wdata_o, mem_be_o});
          else check("mem_write", {mem_addr_o, mem_wdata_o, mem_be_o}, 64'(exp_wr_q.pop_front()));
        end else begin
          if (exp_rd_q.size() == 0) unexpected("mem_read_req", 64'(mem_addr_o));
          else check("mem_read_addr", 64'(mem_addr_o), 64'(exp_rd_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk270);
    #1;
  endtask

  task automatic go_idle(input int cycles);
    bus.hyper_cs_ni = 1'b1;
    bus.ck_en_i     = 1'b1;
    bus.dq_word_i   = 16'h0;
    bus.rwds_pair_i = 2'b00;
    repeat (cycles) tick();
  endtask

  task automatic send_ca(input logic [47:0] ca, input logic lat2x, input int dbl_exp);
    bus.hyper_cs_ni = 1'b0;
    bus.ck_en_i     = 1'b1;
    bus.rwds_pair_i = 2'b00;
    bus.dq_word_i   = ca[47:32];
    lat2x_req_i     = lat2x;
    tick();
    lat2x_req_i = 1'b0;
    if (dbl_exp >= 0)
      check("ca_rwds", 64'({bus.rwds_oe_o, bus.rwds_pair_o}), 64'({1'b1, dbl_exp[0], dbl_exp[0]}));
    bus.dq_word_i = ca[31:16];
    tick();
    bus.dq_word_i = ca[15:0];
    tick();
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic as, input logic lin, input int n,
                            input logic [15:0] rv [4], input logic lat2x, input int dbl_exp,
                            input int lat_exp, input int stall_after, input int stall_len);
    logic [31:0] a;
    logic [15:0] exp_w [4];
    int c = 0, got = 0, first = -1, stalled = 0;
    a = addr;
    for (int k = 0; k <= n; k++) begin
      if (!as) exp_rd_q.push_back(a);
      if (k < n) begin
        exp_w[k] = as ? rv[k] : memf(a);
        exp_data_q.push_back(exp_w[k]);
      end
      a = lin ? a + 32'd1 : {a[31:4], a[3:0] + 4'd1};
    end
    send_ca(mk_ca(1'b1, as, lin, addr), lat2x, dbl_exp);
    while (got < n && c < 200) begin
      c++;
      bus.ck_en_i = 1'b1;
      if (first >= 0 && got == stall_after && stalled < stall_len) begin
        bus.ck_en_i = 1'b0;
        stalled++;
      end
      #1;
      if (bus.dq_oe_o && first < 0) first = c;
      if (!bus.ck_en_i && bus.dq_oe_o) check("stall_hold", 64'(bus.dq_word_o), 64'(exp_w[got]));
      if (bus.dq_oe_o && bus.ck_en_i) got++;
      tick();
    end
    if (got < n) unexpected("read_timeout", 64'(got));
    if (lat_exp >= 0) check("first_data_cycle", 64'(first), 64'(lat_exp + 1));
    bus.hyper_cs_ni = 1'b1;
    tick();
    check("busy_after_cs", 64'({busy_o, bus.dq_oe_o, bus.rwds_oe_o}), 64'(0));
    go_idle(2);
  endtask

  task automatic write_burst(input logic [31:0] addr, input int n, input logic [15:0] d [4],
                             input logic [1:0] m [4]);
    for (int k = 0; k < n; k++)
      if (m[k] != 2'b11) exp_wr_q.push_back({addr + 32'(k), d[k], ~m[k]});
    send_ca(mk_ca(1'b0, 1'b0, 1'b1, addr), 1'b0, 0);
    bus.dq_word_i   = 16'hFFFF;
    bus.rwds_pair_i = 2'b00;
    repeat (WAIT) tick();
    for (int k = 0; k < n; k++) begin
      bus.dq_word_i   = d[k];
      bus.rwds_pair_i = m[k];
      tick();
    end
    bus.hyper_cs_ni = 1'b1;
    bus.dq_word_i   = 16'h1234;
    bus.rwds_pair_i = 2'b00;
    tick();
    check("busy_after_write", 64'(busy_o), 64'(0));
    go_idle(2);
  endtask

  task automatic reg_write(input logic [31:0] addr, input logic [15:0] val);
    send_ca(mk_ca(1'b0, 1'b1, 1'b1, addr), 1'b0, -1);
    bus.dq_word_i = val;
    tick();
    check("done_busy", 64'(busy_o), 64'(1));
    go_idle(1);
    check("reg_wr_idle", 64'(busy_o), 64'(0));
    go_idle(1);
  endtask

  initial begin
    rst_ni          = 1'b0;
    lat2x_req_i     = 1'b0;
    bus.hyper_cs_ni = 1'b1;
    bus.ck_en_i     = 1'b0;
    bus.dq_word_i   = 16'h0;
    bus.rwds_pair_i = 2'b00;
    repeat (3) tick();
    check("reset_outputs", 64'({bus.dq_oe_o, bus.rwds_oe_o, bus.rwds_pair_o, bus.dq_word_o,
                                mem_req_o, mem_we_o, mem_be_o, mem_wdata_o, busy_o}), 64'(0));
    check("reset_addr", 64'(mem_addr_o), 64'(0));
    rst_ni = 1'b1;
    go_idle(2);

    read_burst(32'h800, 1'b1, 1'b1, 2, '{16'h8F1F, 16'h0002, 16'h0, 16'h0}, 1'b0, -1, -1, -1, 0);
    reg_write(32'h800, 16'h8F17);
    read_burst(32'h800, 1'b1, 1'b1, 1, '{16'h8F17, 16'h0, 16'h0, 16'h0}, 1'b0, 0, WAIT, -1, 0);
    read_burst(32'h0, 1'b1, 1'b1, 3, '{16'h0C81, 16'h0001, 16'h0000, 16'h0}, 1'b0, 0, WAIT, -1, 0);
    reg_write(32'h0, 16'hFFFF);
    read_burst(32'h0, 1'b1, 1'b1, 1, '{16'h0C81, 16'h0, 16'h0, 16'h0}, 1'b0, 0, WAIT, -1, 0);

    read_burst(32'h100, 1'b0, 1'b1, 4, '{default: 16'h0}, 1'b0, 0, WAIT, -1, 0);
    write_burst(32'h20, 3, '{16'h1111, 16'h2222, 16'h3333, 16'h0}, '{2'b00, 2'b01, 2'b11, 2'b00});
    read_burst(32'h300, 1'b0, 1'b1, 2, '{default: 16'h0}, 1'b1, 1, 2 * WAIT, -1, 0);
    read_burst(32'h1E, 1'b0, 1'b0, 4, '{default: 16'h0}, 1'b0, 0, WAIT, -1, 0);
    read_burst(32'h40, 1'b0, 1'b1, 4, '{default: 16'h0}, 1'b0, 0, WAIT, 2, 3);
    read_burst(32'h80, 1'b0, 1'b1, 2, '{default: 16'h0}, 1'b0, 0, WAIT, -1, 0);

    // Reset during latency must abort and restore CR0
    send_ca(mk_ca(1'b1, 1'b0, 1'b1, 32'h500), 1'b0, 0);
    repeat (2) tick();
    rst_ni = 1'b0;
    #1;
    check("midop_reset", 64'({busy_o, mem_req_o, bus.rwds_oe_o, bus.dq_oe_o}), 64'(0));
    bus.hyper_cs_ni = 1'b1;
    tick();
    rst_ni = 1'b1;
    go_idle(2);
    read_burst(32'h800, 1'b1, 1'b1, 1, '{16'h8F1F, 16'h0, 16'h0, 16'h0}, 1'b0, -1, -1, -1, 0);

    check("queues_empty", 64'(exp_data_q.size() + exp_rd_q.size() + exp_wr_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
